// File: rtl/prog_loader.sv
// Boot-time loader: packs a little-endian byte stream into 32-bit words and writes them to RAM.
// Define PROG_LOADER_CHECKSUM_EN to build the wrap-around word-sum accumulator on checksum.
module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256,
    parameter bit          BOOT_HOLD = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] num_words,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    output logic        loading,
    output logic        done,
    output logic        cpu_reset_n,
    output logic [31:0] checksum
);
    localparam int               IDX_W   = $clog2(MAX_WORDS) + 1;
    localparam logic [IDX_W-1:0] MAX_N   = IDX_W'(MAX_WORDS);
    localparam logic [IDX_W-1:0] ONE_N   = IDX_W'(1);
    localparam logic [31:0]      MAX_W32 = 32'(MAX_WORDS);

    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] n_q, n_d, idx_q, idx_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [23:0]      shift_q, shift_d;
    logic             zero_pend_q, zero_pend_d;
    logic             byte_ready_q, byte_ready_d;
    logic             mem_valid_q, mem_valid_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_wstrb_q, mem_wstrb_d;
    logic             loading_q, loading_d;
    logic             done_q, done_d;
    logic             cpu_reset_n_q, cpu_reset_n_d;
    logic [IDX_W-1:0] n_req_s, idx_inc_s;
    logic             hs_s;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [31:0]      sum_q, sum_d;
`endif

    assign n_req_s   = ({16'h0000, num_words} > MAX_W32) ? MAX_N : num_words[IDX_W-1:0];
    assign idx_inc_s = idx_q + ONE_N;
    assign hs_s      = byte_valid && byte_ready_q;

    // Next-state and next-output computation for the load sequencer.
    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        idx_d         = idx_q;
        byte_cnt_d    = byte_cnt_q;
        shift_d       = shift_q;
        zero_pend_d   = 1'b0;
        mem_valid_d   = mem_valid_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wstrb_d   = mem_wstrb_q;
        cpu_reset_n_d = cpu_reset_n_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d         = sum_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                // An empty load spends one cycle outside DONE so done visibly drops.
                if (zero_pend_q) begin
                    state_d       = DONE;
                    cpu_reset_n_d = 1'b1;
                end else if (start) begin
                    n_d           = n_req_s;
                    idx_d         = '0;
                    byte_cnt_d    = 2'd0;
                    cpu_reset_n_d = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d         = 32'h0;
`endif
                    if (n_req_s == '0) begin
                        state_d     = IDLE;
                        zero_pend_d = 1'b1;
                    end else begin
                        state_d     = COLLECT;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            COLLECT: begin
                if (hs_s) begin
                    case (byte_cnt_q)
                        2'd0:    shift_d[7:0]   = byte_data;
                        2'd1:    shift_d[15:8]  = byte_data;
                        2'd2:    shift_d[23:16] = byte_data;
                        default: shift_d        = shift_q;
                    endcase
                    if (byte_cnt_q == 2'd3) begin
                        state_d     = WRITE;
                        byte_cnt_d  = 2'd0;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = BASE_ADDR + {{(30-IDX_W){1'b0}}, idx_q, 2'b00};
                        mem_wdata_d = {byte_data, shift_q};
                        mem_wstrb_d = 4'b1111;
                    end else begin
                        byte_cnt_d  = byte_cnt_q + 2'd1;
                    end
                end else begin
                    state_d = COLLECT;
                end
            end
            WRITE: begin
                if (mem_ready && mem_valid_q) begin
                    mem_valid_d = 1'b0;
                    mem_wstrb_d = 4'b0000;
                    idx_d       = idx_inc_s;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d       = sum_q + mem_wdata_q;
`endif
                    if (idx_inc_s == n_q) begin
                        state_d       = DONE;
                        cpu_reset_n_d = 1'b1;
                    end else begin
                        state_d       = COLLECT;
                    end
                end else begin
                    state_d = WRITE;
                end
            end
            default: state_d = IDLE;
        endcase
        byte_ready_d = (state_d == COLLECT);
        loading_d    = (state_d == COLLECT) || (state_d == WRITE);
        done_d       = (state_d == DONE);
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            n_q           <= '0;
            idx_q         <= '0;
            byte_cnt_q    <= 2'd0;
            shift_q       <= 24'h0;
            zero_pend_q   <= 1'b0;
            byte_ready_q  <= 1'b0;
            mem_valid_q   <= 1'b0;
            mem_addr_q    <= BASE_ADDR;
            mem_wdata_q   <= 32'h0;
            mem_wstrb_q   <= 4'b0000;
            loading_q     <= 1'b0;
            done_q        <= 1'b0;
            cpu_reset_n_q <= ~BOOT_HOLD;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            idx_q         <= idx_d;
            byte_cnt_q    <= byte_cnt_d;
            shift_q       <= shift_d;
            zero_pend_q   <= zero_pend_d;
            byte_ready_q  <= byte_ready_d;
            mem_valid_q   <= mem_valid_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wstrb_q   <= mem_wstrb_d;
            loading_q     <= loading_d;
            done_q        <= done_d;
            cpu_reset_n_q <= cpu_reset_n_d;
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Word-sum accumulator flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= 32'h0;
        end else begin
            sum_q <= sum_d;
        end
    end
    assign checksum = sum_q;
`else
    assign checksum = 32'h0;
`endif

    assign byte_ready  = byte_ready_q;
    assign mem_valid   = mem_valid_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wstrb   = mem_wstrb_q;
    assign loading     = loading_q;
    assign done        = done_q;
    assign cpu_reset_n = cpu_reset_n_q;
endmodule
